rc5_encrypt8: RTL and testbench
===============================

# rc5_encrypt8

RC5 encryptor on 8-bit words (RC5-8/R): the forward-direction counterpart to the team's 8-bit RC5 decryption core. Takes a 16-bit plaintext block as two 8-bit halves and produces the 16-bit ciphertext block. Uses the same expanded-key (S) table layout, so its ciphertext decrypts directly with the decryption core. Sits between the host key/data registers and the cipher datapath. The S table is loaded through a write port; a start/busy/done handshake frames each block.

## Interface
- ROUNDS, default 2: number of RC5 rounds, legal range 1..6. The S table holds T = 2*ROUNDS+2 entries.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_we  in  1  S-table write strobe.
- key_addr  in  4  S-table index.
- key_wdata  in  8  S-table write data.
- start  in  1  request to encrypt pt_a/pt_b.
- pt_a  in  8  plaintext word A.
- pt_b  in  8  plaintext word B.
- busy  out  1  high while a block is in progress.
- done  out  1  one-cycle pulse; ct_a/ct_b are valid from this cycle.
- ct_a  out  8  ciphertext word A; held until the next done.
- ct_b  out  8  ciphertext word B; held until the next done.

## Operation
- Algorithm; all sums are mod 256 and rotl is a left rotate by (amount & 7):
  - A = pt_a + S[0]; B = pt_b + S[1].
  - For i = 1..ROUNDS: A = rotl(A ^ B, B) + S[2i]; then B = rotl(B ^ A, A) + S[2i+1], using the just-updated A.
- Rotation is a single-cycle 8-bit barrel rotate. A rotate amount of 0 is the identity.
- S-table writes:
  - Accepted when key_we=1, busy=0 and key_addr < T.
  - Writes are ignored otherwise, with no error flag.
  - A write in the same cycle as an accepted start completes before the block uses the table.
- FSM states:
  - IDLE: on start=1, load A=pt_a and B=pt_b, clear the round counter, go to PRE.
  - PRE: add S[0] and S[1]; round=1; go to RA.
  - RA: compute A for the current round; go to RB.
  - RB: compute B for the current round.
    - If round < ROUNDS: round+1, go to RA.
    - Otherwise: ct_a <= A, ct_b <= new B, done <= 1, go to IDLE.
- busy = (state != IDLE).
- start is ignored while busy.
- Reset (asserted at any time, including mid-block):
  - State goes to IDLE; A, B, the round counter, ct_a, ct_b, busy and done all become 0.
  - All S entries become 0.
  - Any in-flight block is discarded and no done is produced for it.

## Timing
- Start is accepted at rising edge k (state IDLE, start=1).
- busy is high from the cycle after edge k until edge k+1+2*ROUNDS.
- done is high for exactly the one cycle following edge k+1+2*ROUNDS. Latency is 2*ROUNDS+2 cycles; for ROUNDS=2 that is 6.
- The FSM is already in IDLE during the done cycle, so start may be asserted there. Back-to-back throughput is one block per 2*ROUNDS+2 cycles.
- ct_a/ct_b update only at the edge that raises done.
- Inputs pt_a/pt_b are sampled only at the start edge; later changes have no effect.

## Test plan
- Reset: drive reset low mid-idle -> busy=0, done=0, ct_a=0x00, ct_b=0x00; all S entries read back as 0 (observed via encrypt with pt 0x00/0x00 -> ct 0x00/0x00).
- Zero key, ROUNDS=2: S all 0x00, pt_a=0x01, pt_b=0x00 -> done exactly 6 cycles after the start edge; ct_a=0x0C, ct_b=0xE0.
- Loaded key, ROUNDS=2: S[0..5] = 0x50, 0xA8, 0xC8, 0xD0, 0x38, 0x58; pt_a=0x0A, pt_b=0x0B -> ct_a=0x0C, ct_b=0x3A. Feeding that result through the decryption core returns 0x0A/0x0B.
- Ignored requests while busy, same key as above:
  - Pulse start with different pt, and key_we to S[2] with 0xFF, mid-block -> still ct_a=0x0C, ct_b=0x3A.
  - A second identical block gives the same result, confirming S[2] was unchanged.
  - A write to key_addr=9 (out of range) has no effect.
- Back-to-back: assert start in the done cycle with pt 0x01/0x00 under the zero key -> second done exactly 6 cycles later with ct 0x0C/0xE0; first ct held until then.
- Reset mid-block: assert reset during RA of round 2 -> busy drops immediately (asynchronous), no done pulse, ct_a=ct_b=0x00. After release, S must be reloaded before the known answer reappears.

Source files
------------

// File: rtl/rc5_encrypt8_if.sv
// ---------------------------------------------------------------------------
// rc5_encrypt8_if
//
// Purpose:
//   Groups the host-facing signals of the RC5-8 encryptor.
//   The host (master) drives the expanded-key write port and the plaintext
//   request. The encryptor (slave) returns the handshake status and the
//   ciphertext.
//
// Signals:
//   key_we     host -> core   S-table write strobe
//   key_addr   host -> core   S-table index (4 bits)
//   key_wdata  host -> core   S-table write data (8 bits)
//   start      host -> core   request to encrypt pt_a/pt_b
//   pt_a/pt_b  host -> core   plaintext words (8 bits each)
//   busy       core -> host   block in progress
//   done       core -> host   one-cycle pulse, ciphertext valid from here on
//   ct_a/ct_b  core -> host   ciphertext words, held until the next done
// ---------------------------------------------------------------------------
interface rc5_encrypt8_if;

    logic       key_we;
    logic [3:0] key_addr;
    logic [7:0] key_wdata;
    logic       start;
    logic [7:0] pt_a;
    logic [7:0] pt_b;
    logic       busy;
    logic       done;
    logic [7:0] ct_a;
    logic [7:0] ct_b;

    // Host side: drives requests and key writes, observes the results.
    modport master (
        output key_we,
        output key_addr,
        output key_wdata,
        output start,
        output pt_a,
        output pt_b,
        input  busy,
        input  done,
        input  ct_a,
        input  ct_b
    );

    // Encryptor side: the mirror image of the host view.
    modport slave (
        input  key_we,
        input  key_addr,
        input  key_wdata,
        input  start,
        input  pt_a,
        input  pt_b,
        output busy,
        output done,
        output ct_a,
        output ct_b
    );

endinterface

// File: rtl/rc5_encrypt8.sv
// ---------------------------------------------------------------------------
// rc5_encrypt8
//
// Purpose:
//   RC5-8/R block encryptor. It takes a 16-bit plaintext block as two 8-bit
//   halves and produces the 16-bit ciphertext. The expanded-key (S) table
//   layout matches the 8-bit RC5 decryption core, so ciphertext from this
//   block decrypts directly there.
//
//   Algorithm (all sums mod 256, rotl by amount & 7):
//     A = pt_a + S[0];  B = pt_b + S[1]
//     for i = 1..ROUNDS:
//       A = rotl(A ^ B, B) + S[2i]
//       B = rotl(B ^ A, A) + S[2i+1]   (uses the freshly updated A)
//
//   Each half-round takes one cycle. A block takes 2*ROUNDS+2 cycles from
//   the start edge to the cycle that carries done.
//
// Parameters:
//   ROUNDS   number of rounds, legal range 1..6. The table holds
//            T = 2*ROUNDS+2 entries.
//
// Ports:
//   clock    single clock, rising-edge active
//   reset    asynchronous, active-low reset. Clears the FSM, the datapath,
//            the outputs and the whole S table.
//   bus      rc5_encrypt8_if.slave: key write port, start/pt request,
//            busy/done/ct results
// ---------------------------------------------------------------------------
module rc5_encrypt8 #(
    parameter int ROUNDS = 2
) (
    input  logic           clock,
    input  logic           reset,
    rc5_encrypt8_if.slave  bus
);

    localparam int T  = 2 * ROUNDS + 2;
    localparam int AW = $clog2(T);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RA   = 2'd2,
        RB   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [2:0]    round_q, round_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    ct_a_q, ct_a_d;
    logic [7:0]    ct_b_q, ct_b_d;
    logic [7:0]    s_q [T];
    logic [7:0]    s_d [T];

    logic          key_ok;
    logic [AW-1:0] even_idx;
    logic [AW-1:0] odd_idx;
    logic [7:0]    new_a;
    logic [7:0]    new_b;

    // 8-bit left rotate. Only the low three bits of the amount matter, and
    // a zero amount passes the value through untouched.
    function automatic logic [7:0] rotl8(input logic [7:0] value,
                                         input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} << amount;
        return doubled[15:8];
    endfunction

    // Key writes are accepted only while idle and only for indices inside
    // the table. Because the table updates on the same edge that accepts
    // start, and the first table read happens in PRE one cycle later,
    // a write issued together with start is visible to that block.
    always_comb begin
        key_ok = bus.key_we && !busy_q && (int'(bus.key_addr) < T);
        for (int i = 0; i < T; i++) begin
            s_d[i] = s_q[i];
        end
        if (key_ok) begin
            s_d[bus.key_addr[AW-1:0]] = bus.key_wdata;
        end
    end

    // Round datapath. RA produces the new A from the current A and B.
    // RB produces the new B from B and the A that RA just stored. The round
    // counter stays in 1..ROUNDS while these results are used, so both
    // indices stay inside the table.
    always_comb begin
        even_idx = AW'(2 * round_q);
        odd_idx  = AW'(2 * round_q + 1);
        new_a    = rotl8(a_q ^ b_q, b_q[2:0]) + s_q[even_idx];
        new_b    = rotl8(b_q ^ a_q, a_q[2:0]) + s_q[odd_idx];
    end

    // Next-state and next-output logic for the block sequencer.
    // done is a one-cycle pulse, so it defaults low every cycle. The
    // ciphertext registers change only on the final RB, which keeps the
    // previous result visible for the whole of the next block.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ct_a_d  = ct_a_q;
        ct_b_d  = ct_b_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.pt_a;
                    b_d     = bus.pt_b;
                    round_d = 3'd0;
                    busy_d  = 1'b1;
                    state_d = PRE;
                end
            end
            PRE: begin
                a_d     = a_q + s_q[0];
                b_d     = b_q + s_q[1];
                round_d = 3'd1;
                state_d = RA;
            end
            RA: begin
                a_d     = new_a;
                state_d = RB;
            end
            RB: begin
                b_d = new_b;
                if (round_q != 3'(ROUNDS)) begin
                    round_d = round_q + 3'd1;
                    state_d = RA;
                end else begin
                    ct_a_d  = a_q;
                    ct_b_d  = new_b;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All state lives here. Reset wipes the in-flight block, the held
    // ciphertext and the S table, so a block interrupted by reset never
    // raises done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            round_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ct_a_q  <= 8'h00;
            ct_b_q  <= 8'h00;
            for (int i = 0; i < T; i++) begin
                s_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ct_a_q  <= ct_a_d;
            ct_b_q  <= ct_b_d;
            s_q     <= s_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ct_a = ct_a_q;
    assign bus.ct_b = ct_b_q;

endmodule

// File: tb/tb_rc5_encrypt8.sv
// ---------------------------------------------------------------------------
// tb_rc5_encrypt8
//
// Purpose:
//   Self-checking bench for rc5_encrypt8 with ROUNDS = 2.
//
//   A behavioural model tracks the S table, the busy window, the done pulse
//   and the held ciphertext. It computes each block's result with plain
//   integer arithmetic straight from the cipher definition. A compare
//   process checks every DUT output against the model on each falling edge.
//
//   The directed sequence also pins known answers as literals: the
//   zero-key and loaded-key vectors, the start-to-done latency, the
//   behaviour of requests made while busy, back-to-back blocks and reset
//   in the middle of a block.
// ---------------------------------------------------------------------------
module tb_rc5_encrypt8;

    localparam int R   = 2;
    localparam int T   = 2 * R + 2;
    localparam int LAT = 2 * R + 2;

    localparam logic [47:0] LOADED_KEY = 48'h50_A8_C8_D0_38_58;
    localparam logic [47:0] ZERO_KEY   = 48'h00_00_00_00_00_00;

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] m_s [T];
    logic       m_busy   = 1'b0;
    logic       m_done   = 1'b0;
    logic [7:0] m_ct_a   = 8'h00;
    logic [7:0] m_ct_b   = 8'h00;
    logic [7:0] m_pend_a = 8'h00;
    logic [7:0] m_pend_b = 8'h00;
    int         m_left   = 0;

    rc5_encrypt8_if bus ();

    rc5_encrypt8 #(.ROUNDS(R)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Counts every comparison and reports any mismatch on a single line.
    task automatic checkOutput(input string name,
                               input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs from a falling edge. The values are
    // captured at the next rising edge, and the task returns at the
    // falling edge after it.
    task automatic applyStimulus(input logic       we,
                                 input logic [3:0] addr,
                                 input logic [7:0] wdata,
                                 input logic       st,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
        bus.key_we    = we;
        bus.key_addr  = addr;
        bus.key_wdata = wdata;
        bus.start     = st;
        bus.pt_a      = a;
        bus.pt_b      = b;
        @(negedge clock);
        bus.key_we = 1'b0;
        bus.start  = 1'b0;
    endtask

    task automatic load_key(input logic [47:0] key);
        for (int i = 0; i < T; i++) begin
            applyStimulus(1'b1, 4'(i), key[47 - 8 * i -: 8], 1'b0, 8'h00, 8'h00);
        end
    endtask

    // elapsed = number of rising edges since the start edge, counting the
    // start edge itself as 1. Returns in the done cycle.
    task automatic wait_done(input string name, input int elapsed,
                             input logic [7:0] exp_a, input logic [7:0] exp_b);
        int n;
        n = elapsed;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checkOutput({name, "_latency"}, 32'(n), 32'(LAT));
        checkOutput({name, "_ct_a"}, 32'(bus.ct_a), 32'(exp_a));
        checkOutput({name, "_ct_b"}, 32'(bus.ct_b), 32'(exp_b));
    endtask

    task automatic run_block(input string name,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_a, input logic [7:0] exp_b);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, a, b);
        wait_done(name, 1, exp_a, exp_b);
    endtask

    // Reference cipher, written directly from the RC5 definition.
    function automatic int rot_int(input int x, input int n);
        return ((x << n) | (x >> (8 - n))) & 255;
    endfunction

    function automatic logic [15:0] model_encrypt(input logic [7:0] pa,
                                                  input logic [7:0] pb);
        int a;
        int b;
        a = (pa + m_s[0]) % 256;
        b = (pb + m_s[1]) % 256;
        for (int r = 1; r <= R; r++) begin
            a = (rot_int(a ^ b, b % 8) + m_s[2 * r]) % 256;
            b = (rot_int(b ^ a, a % 8) + m_s[2 * r + 1]) % 256;
        end
        return {a[7:0], b[7:0]};
    endfunction

    // Model of the externally visible behaviour: busy for 2R+2 edges after
    // an idle start, done in the cycle after the last of them, key writes
    // only while idle and in range, and reset clearing everything.
    initial begin
        for (int i = 0; i < T; i++) m_s[i] = 8'h00;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                for (int i = 0; i < T; i++) m_s[i] = 8'h00;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_ct_a = 8'h00;
                m_ct_b = 8'h00;
                m_left = 0;
            end else begin
                if (bus.key_we && !m_busy && int'(bus.key_addr) < T)
                    m_s[int'(bus.key_addr)] = bus.key_wdata;
                m_done = 1'b0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_ct_a = m_pend_a;
                        m_ct_b = m_pend_b;
                    end
                end else if (bus.start) begin
                    {m_pend_a, m_pend_b} = model_encrypt(bus.pt_a, bus.pt_b);
                    m_busy = 1'b1;
                    m_left = 2 * R + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        checkOutput("model_busy", 32'(bus.busy), 32'(m_busy));
        checkOutput("model_done", 32'(bus.done), 32'(m_done));
        checkOutput("model_ct_a", 32'(bus.ct_a), 32'(m_ct_a));
        checkOutput("model_ct_b", 32'(bus.ct_b), 32'(m_ct_b));
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.key_we    = 1'b0;
        bus.key_addr  = 4'd0;
        bus.key_wdata = 8'h00;
        bus.start     = 1'b0;
        bus.pt_a      = 8'h00;
        bus.pt_b      = 8'h00;
        reset         = 1'b1;
        #2 reset      = 1'b0;

        repeat (2) @(negedge clock);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_done", 32'(bus.done), 32'h0);
        checkOutput("reset_ct_a", 32'(bus.ct_a), 32'h00);
        checkOutput("reset_ct_b", 32'(bus.ct_b), 32'h00);
        #1 reset = 1'b1;
        @(negedge clock);

        // Cleared table, then the zero-key vector.
        run_block("zero_pt", 8'h00, 8'h00, 8'h00, 8'h00);
        run_block("zero_key", 8'h01, 8'h00, 8'h0C, 8'hE0);

        // Loaded key.
        load_key(LOADED_KEY);
        run_block("loaded_key", 8'h0A, 8'h0B, 8'h0C, 8'h3A);

        // Start and key write while busy must be ignored.
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 8'h0A, 8'h0B);
        @(negedge clock);
        applyStimulus(1'b1, 4'd2, 8'hFF, 1'b1, 8'h55, 8'h66);
        wait_done("busy_ignore", 3, 8'h0C, 8'h3A);
        @(negedge clock);
        run_block("same_again", 8'h0A, 8'h0B, 8'h0C, 8'h3A);

        // An out-of-range key index must not alias into the table.
        applyStimulus(1'b1, 4'd9, 8'hFF, 1'b0, 8'h00, 8'h00);
        run_block("after_addr9", 8'h0A, 8'h0B, 8'h0C, 8'h3A);

        // Back-to-back under the zero key: start in the done cycle.
        load_key(ZERO_KEY);
        run_block("b2b_first", 8'h0A, 8'h0B, 8'h58, 8'h5B);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 8'h01, 8'h00);
        checkOutput("b2b_held_ct_a", 32'(bus.ct_a), 32'h58);
        checkOutput("b2b_held_ct_b", 32'(bus.ct_b), 32'h5B);
        checkOutput("b2b_busy", 32'(bus.busy), 32'h1);
        wait_done("b2b_second", 1, 8'h0C, 8'hE0);

        // Reset during RA of round 2.
        load_key(LOADED_KEY);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 8'h0A, 8'h0B);
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("mid_reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("mid_reset_done", 32'(bus.done), 32'h0);
        checkOutput("mid_reset_ct_a", 32'(bus.ct_a), 32'h00);
        checkOutput("mid_reset_ct_b", 32'(bus.ct_b), 32'h00);
        @(negedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checkOutput("no_done_after_reset", 32'(bus.done), 32'h0);
        end

        // Table was wiped, so the loaded-key answer is gone until reload.
        run_block("key_cleared", 8'h0A, 8'h0B, 8'h58, 8'h5B);
        load_key(LOADED_KEY);
        run_block("reloaded", 8'h0A, 8'h0B, 8'h0C, 8'h3A);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
